mips_fetch_pc: RTL

- Instruction-fetch/PC stage sitting directly upstream of the Harvard CPU datapath.
- Drives `instr_address` to instruction memory and forwards the combinational `instr_readdata` to decode.
- Sequences the PC through MIPS branch delay slots.
- Detects the halt condition (jump to address 0), which deasserts `active`, and misaligned redirect targets, which latch a fault.

---
 rtl/mips_fetch_pc.sv | 78 +++++++
 1 files changed

// File: rtl/mips_fetch_pc.sv
// mips_fetch_pc: MIPS instruction-fetch PC stage with branch delay slots, halt on jump-to-zero and misaligned-target fault.
//   clk, reset (async active-high), clk_enable gates every state update.
//   redirect_valid/redirect_target: taken branch/jump from decode/execute.
//   instr_readdata in -> instr out (NOP when not valid); instr_address is the registered PC.
//   pc_plus8 is the link value; in_delay_slot/active/fault/fetch_count report stage status.
module mips_fetch_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_address,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_plus8,
    output logic        in_delay_slot,
    output logic        active,
    output logic        fault,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {SEQ, DELAY_SLOT, HALTED, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, target_q, target_d, count_q, count_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEQ;
            pc_q     <= RESET_VECTOR;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end
    // The delay slot is fetched sequentially; the branch target is loaded on the following edge.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        count_d  = count_q;
        if (clk_enable) begin
            case (state_q)
                SEQ: begin
                    if (redirect_valid && redirect_target[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        count_d = count_q + 32'd1;
                        if (redirect_valid) begin
                            target_d = redirect_target;
                            state_d  = DELAY_SLOT;
                        end
                    end
                end
                DELAY_SLOT: begin
                    pc_d    = target_q;
                    count_d = count_q + 32'd1;
                    state_d = (target_q == HALT_ADDR) ? HALTED : SEQ;
                end
                default: ;
            endcase
        end
    end
    assign instr_address = pc_q;
    assign fetch_count   = count_q;
    assign in_delay_slot = state_q == DELAY_SLOT;
    assign active        = state_q == SEQ || state_q == DELAY_SLOT;
    assign fault         = state_q == FAULT;
    assign instr_valid   = active & ~fault;
    assign instr         = instr_valid ? instr_readdata : 32'h00000000;
    assign pc_plus8      = pc_q + 32'd8;
endmodule
